// File: rtl/regfile_wb_scheduler.sv
// regfile_wb_scheduler: scoreboard for in-flight long-latency (mult/div) ops
// plus a single-write-port arbiter between ALU writeback and the long-latency
// unit. A one-entry holding buffer parks an md result that loses the port to
// the ALU. While that buffer is full, decode is held so the ALU pipeline drains
// and the buffer gets a free port cycle.
module regfile_wb_scheduler #(
  parameter int MAX_MD = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic [4:0]  id_rd,
  input  logic        id_regwrite,
  input  logic        id_long,
  output logic        stall,
  output logic        issue,
  input  logic        alu_wb_valid,
  input  logic [4:0]  alu_wb_rd,
  input  logic [31:0] alu_wb_data,
  input  logic        md_wb_valid,
  input  logic [4:0]  md_wb_rd,
  input  logic [31:0] md_wb_data,
  output logic        md_wb_ready,
  output logic        rf_regwrite,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_writedata,
  output logic [31:0] busy,
  output logic [2:0]  md_pending
);

  localparam logic [2:0] MAX_MD_C = 3'(MAX_MD);

  logic [31:0] busy_q, busy_d;
  logic [2:0]  md_pending_q, md_pending_d;
  logic        buf_full_q, buf_full_d;
  logic [4:0]  buf_rd_q, buf_rd_d;
  logic [31:0] buf_data_q, buf_data_d;

  logic        hazard_s;
  logic        md_accept_s;
  logic        md_commit_s;
  logic [4:0]  commit_rd_s;
  logic        long_issue_s;
  logic        capture_s;
  logic [31:0] clr_mask_s;
  logic [31:0] set_mask_s;

  // Decode-side hazard detection, issue qualification and md handshake.
  always_comb begin
    hazard_s    = (id_uses_rs & busy_q[id_rs])
                | (id_uses_rt & busy_q[id_rt])
                | (id_regwrite & busy_q[id_rd])
                | (id_long & (md_pending_q == MAX_MD_C))
                | buf_full_q;
    stall        = id_valid & ~rst & hazard_s;
    issue        = id_valid & ~stall & ~rst;
    md_wb_ready  = ~buf_full_q & ~rst;
    md_accept_s  = md_wb_valid & md_wb_ready;
    long_issue_s = issue & id_long;
  end

  // Write-port arbitration: ALU first, then the holding buffer, then direct md.
  // Writes addressed to r0 still occupy the port but never assert regwrite.
  always_comb begin
    rf_regwrite  = 1'b0;
    rf_rd        = 5'd0;
    rf_writedata = 32'd0;
    md_commit_s  = 1'b0;
    commit_rd_s  = 5'd0;
    if (rst) begin
      rf_regwrite = 1'b0;
    end else if (alu_wb_valid) begin
      rf_regwrite  = (alu_wb_rd != 5'd0);
      rf_rd        = alu_wb_rd;
      rf_writedata = alu_wb_data;
    end else if (buf_full_q) begin
      rf_regwrite  = (buf_rd_q != 5'd0);
      rf_rd        = buf_rd_q;
      rf_writedata = buf_data_q;
      md_commit_s  = 1'b1;
      commit_rd_s  = buf_rd_q;
    end else if (md_accept_s) begin
      rf_regwrite  = (md_wb_rd != 5'd0);
      rf_rd        = md_wb_rd;
      rf_writedata = md_wb_data;
      md_commit_s  = 1'b1;
      commit_rd_s  = md_wb_rd;
    end else begin
      rf_regwrite = 1'b0;
    end
  end

  // Next-state for scoreboard, pending counter and holding buffer.
  // The set mask is applied after the clear so a same-edge set wins.
  always_comb begin
    clr_mask_s   = md_commit_s  ? (32'd1 << commit_rd_s) : 32'd0;
    set_mask_s   = long_issue_s ? (32'd1 << id_rd)       : 32'd0;
    busy_d       = ((busy_q & ~clr_mask_s) | set_mask_s) & 32'hFFFF_FFFE;
    md_pending_d = md_pending_q + {2'b00, long_issue_s} - {2'b00, md_commit_s};
    // Buffer is only ever loaded when it is empty (md_wb_ready gates accept).
    capture_s    = alu_wb_valid & md_accept_s;
    buf_full_d   = capture_s | (buf_full_q & alu_wb_valid);
    buf_rd_d     = capture_s ? md_wb_rd   : buf_rd_q;
    buf_data_d   = capture_s ? md_wb_data : buf_data_q;
  end

  // State registers with synchronous reset; reset drops any buffered result.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q       <= 32'd0;
      md_pending_q <= 3'd0;
      buf_full_q   <= 1'b0;
      buf_rd_q     <= 5'd0;
      buf_data_q   <= 32'd0;
    end else begin
      busy_q       <= busy_d;
      md_pending_q <= md_pending_d;
      buf_full_q   <= buf_full_d;
      buf_rd_q     <= buf_rd_d;
      buf_data_q   <= buf_data_d;
    end
  end

  assign busy       = busy_q;
  assign md_pending = md_pending_q;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Bench for regfile_wb_scheduler: a transaction-level model (register set,
// pending count, result queue) checked against the DUT on every falling edge,
// plus directed scenarios with hand-computed literal expectations.
module tb_regfile_wb_scheduler;
  localparam int MAX_MD = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_uses_rs, id_uses_rt, id_regwrite, id_long;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        stall, issue;
  logic        alu_wb_valid, md_wb_valid, md_wb_ready;
  logic [4:0]  alu_wb_rd, md_wb_rd, rf_rd;
  logic [31:0] alu_wb_data, md_wb_data, rf_writedata, busy;
  logic        rf_regwrite;
  logic [2:0]  md_pending;

  regfile_wb_scheduler #(.MAX_MD(MAX_MD)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_long(id_long),
    .stall(stall), .issue(issue),
    .alu_wb_valid(alu_wb_valid), .alu_wb_rd(alu_wb_rd), .alu_wb_data(alu_wb_data),
    .md_wb_valid(md_wb_valid), .md_wb_rd(md_wb_rd), .md_wb_data(md_wb_data),
    .md_wb_ready(md_wb_ready),
    .rf_regwrite(rf_regwrite), .rf_rd(rf_rd), .rf_writedata(rf_writedata),
    .busy(busy), .md_pending(md_pending)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Register file written from the DUT's write port.
  logic [31:0] rf [32];
  always @(posedge clk) begin
    if (rf_regwrite) rf[rf_rd] <= rf_writedata;
  end

  // ---------------- behavioural model ----------------
  typedef struct { logic [4:0] rd; logic [31:0] data; } res_t;
  bit [31:0] m_busy = 32'd0;
  int        m_pend = 0;
  res_t      m_buf[$];

  logic        e_stall, e_issue, e_ready, e_we;
  logic [4:0]  e_rd;
  logic [31:0] e_data;
  int          e_src; // 0 none, 1 alu, 2 parked md, 3 direct md

  task automatic model_eval();
    bit hz;
    e_ready = !rst && (m_buf.size() == 0);
    hz = (id_uses_rs && m_busy[id_rs]) || (id_uses_rt && m_busy[id_rt]) ||
         (id_regwrite && m_busy[id_rd]) || (id_long && m_pend == MAX_MD) ||
         (m_buf.size() != 0);
    e_stall = !rst && id_valid && hz;
    e_issue = !rst && id_valid && !e_stall;
    e_src = 0; e_rd = 5'd0; e_data = 32'd0;
    if (!rst) begin
      if (alu_wb_valid) begin
        e_src = 1; e_rd = alu_wb_rd; e_data = alu_wb_data;
      end else if (m_buf.size() != 0) begin
        e_src = 2; e_rd = m_buf[0].rd; e_data = m_buf[0].data;
      end else if (md_wb_valid) begin
        e_src = 3; e_rd = md_wb_rd; e_data = md_wb_data;
      end
    end
    e_we = (e_src != 0) && (e_rd != 5'd0);
  endtask

  // Inputs are stable from posedge+1 to the next posedge, so the falling edge
  // sees exactly what the next rising edge will consume: compare, then advance.
  always @(negedge clk) begin
    if (chk_en) begin
      model_eval();
      chk("stall",        {31'd0, stall},       {31'd0, e_stall});
      chk("issue",        {31'd0, issue},       {31'd0, e_issue});
      chk("md_wb_ready",  {31'd0, md_wb_ready}, {31'd0, e_ready});
      chk("rf_regwrite",  {31'd0, rf_regwrite}, {31'd0, e_we});
      chk("rf_rd",        {27'd0, rf_rd},       {27'd0, e_rd});
      chk("rf_writedata", rf_writedata,         e_data);
      chk("busy",         busy,                 m_busy);
      chk("md_pending",   {29'd0, md_pending},  32'(m_pend));
      if (rst) begin
        m_busy = 32'd0; m_pend = 0; m_buf.delete();
      end else begin
        if (e_src == 2 || e_src == 3) begin
          m_busy[e_rd] = 1'b0;
          m_pend--;
        end
        if (e_src == 2) void'(m_buf.pop_front());
        if (alu_wb_valid && md_wb_valid && e_ready) m_buf.push_back('{md_wb_rd, md_wb_data});
        if (e_issue && id_long) begin
          m_pend++;
          if (id_rd != 5'd0) m_busy[id_rd] = 1'b1;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic look();
    @(negedge clk); #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt, input logic [4:0] rd,
                        input logic rw, input logic lg);
    id_valid = v; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
    id_rd = rd; id_regwrite = rw; id_long = lg;
  endtask

  task automatic set_alu(input logic v, input logic [4:0] rd, input logic [31:0] d);
    alu_wb_valid = v; alu_wb_rd = rd; alu_wb_data = d;
  endtask

  task automatic set_md(input logic v, input logic [4:0] rd, input logic [31:0] d);
    md_wb_valid = v; md_wb_rd = rd; md_wb_data = d;
  endtask

  task automatic idle();
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    set_alu(1'b0, 5'd0, 32'd0);
    set_md(1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    idle();
    rst = 1'b1;
    step();
    chk_en = 1'b1;
    // During reset: everything quiet even with a valid decode.
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
    look();
    chk("rst_issue", {31'd0, issue}, 32'd0);
    chk("rst_ready", {31'd0, md_wb_ready}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    step();
    rst = 1'b0;
    look();
    chk("post_rst_busy", busy, 32'd0);
    chk("post_rst_pend", {29'd0, md_pending}, 32'd0);
    chk("post_rst_ready", {31'd0, md_wb_ready}, 32'd1);
    chk("post_rst_issue", {31'd0, issue}, 32'd1);
    step();

    // Hazard clear on r5.
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1);
    look(); chk("h_issue_long", {31'd0, issue}, 32'd1);
    step();
    set_id(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    look(); chk("h_stall", {31'd0, stall}, 32'd1); chk("h_busy", busy, 32'h0000_0020);
    step();
    step();
    set_md(1'b1, 5'd5, 32'hAAAA_5555);
    look(); chk("h_commit_we", {31'd0, rf_regwrite}, 32'd1);
    chk("h_commit_rd", {27'd0, rf_rd}, 32'd5); chk("h_commit_stall", {31'd0, stall}, 32'd1);
    step();
    set_md(1'b0, 5'd0, 32'd0);
    look(); chk("h_busy_clr", busy, 32'd0); chk("h_stall_drop", {31'd0, stall}, 32'd0);
    chk("h_rf5", rf[5], 32'hAAAA_5555);
    step();

    // Write collision: ALU r3 vs md r7.
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b1);
    step();
    set_id(1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    set_alu(1'b1, 5'd3, 32'h0000_0011);
    set_md(1'b1, 5'd7, 32'h0000_0022);
    look(); chk("c_rd_alu", {27'd0, rf_rd}, 32'd3); chk("c_data_alu", rf_writedata, 32'h11);
    step();
    set_alu(1'b1, 5'd4, 32'h0000_0033);
    set_md(1'b0, 5'd0, 32'd0);
    look(); chk("c_ready_low", {31'd0, md_wb_ready}, 32'd0);
    chk("c_stall_buf", {31'd0, stall}, 32'd1); chk("c_busy7", busy, 32'h0000_0080);
    step();
    set_alu(1'b0, 5'd0, 32'd0);
    look(); chk("c_drain_rd", {27'd0, rf_rd}, 32'd7); chk("c_drain_data", rf_writedata, 32'h22);
    step();
    look(); chk("c_busy_clr", busy, 32'd0); chk("c_ready_back", {31'd0, md_wb_ready}, 32'd1);
    chk("c_rf3", rf[3], 32'h11); chk("c_rf4", rf[4], 32'h33); chk("c_rf7", rf[7], 32'h22);
    step();

    // Pending limit.
    for (int r = 1; r <= 4; r++) begin
      set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'(r), 1'b1, 1'b1);
      step();
    end
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd6, 1'b1, 1'b1);
    look(); chk("p_pend4", {29'd0, md_pending}, 32'd4); chk("p_stall5", {31'd0, stall}, 32'd1);
    chk("p_busy", busy, 32'h0000_001E);
    step();
    set_md(1'b1, 5'd1, 32'h0000_0101);
    look(); chk("p_stall_at_max", {31'd0, stall}, 32'd1);
    step();
    set_md(1'b1, 5'd2, 32'h0000_0202);
    look(); chk("p_pend3", {29'd0, md_pending}, 32'd3); chk("p_issue6", {31'd0, issue}, 32'd1);
    step();
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    set_md(1'b1, 5'd3, 32'h0000_0303);
    look(); chk("p_pend_same", {29'd0, md_pending}, 32'd3); chk("p_busy2", busy, 32'h0000_0058);
    step();
    set_md(1'b1, 5'd4, 32'h0000_0404); step();
    set_md(1'b1, 5'd6, 32'h0000_0606); step();
    set_md(1'b0, 5'd0, 32'd0);
    look(); chk("p_pend0", {29'd0, md_pending}, 32'd0); chk("p_busy0", busy, 32'd0);
    step();

    // r0 destination.
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
    step();
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    look(); chk("z_pend1", {29'd0, md_pending}, 32'd1); chk("z_busy", busy, 32'd0);
    step();
    set_md(1'b1, 5'd0, 32'h0000_0005);
    look(); chk("z_we0", {31'd0, rf_regwrite}, 32'd0);
    step();
    set_md(1'b0, 5'd0, 32'd0);
    look(); chk("z_pend0", {29'd0, md_pending}, 32'd0);
    step();

    // WAW on r9.
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, 1'b1);
    step();
    set_id(1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd9, 1'b1, 1'b0);
    look(); chk("w_stall", {31'd0, stall}, 32'd1);
    step();
    set_md(1'b1, 5'd9, 32'h0000_0099);
    look(); chk("w_stall_commit", {31'd0, stall}, 32'd1);
    step();
    set_md(1'b0, 5'd0, 32'd0);
    look(); chk("w_stall_drop", {31'd0, stall}, 32'd0); chk("w_issue", {31'd0, issue}, 32'd1);
    step();

    // Reset with a full buffer and r8 busy.
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd8, 1'b1, 1'b1);
    step();
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    set_alu(1'b1, 5'd10, 32'h0000_000A);
    set_md(1'b1, 5'd8, 32'h0000_0088);
    step();
    set_alu(1'b1, 5'd11, 32'h0000_000B);
    set_md(1'b0, 5'd0, 32'd0);
    look(); chk("r_busy", busy, 32'h0000_0100); chk("r_ready0", {31'd0, md_wb_ready}, 32'd0);
    step();
    rst = 1'b1;
    set_alu(1'b0, 5'd0, 32'd0);
    set_id(1'b1, 5'd8, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    look(); chk("r_we_rst", {31'd0, rf_regwrite}, 32'd0); chk("r_stall_rst", {31'd0, stall}, 32'd0);
    step();
    rst = 1'b0;
    look(); chk("r_busy0", busy, 32'd0); chk("r_pend0", {29'd0, md_pending}, 32'd0);
    chk("r_ready1", {31'd0, md_wb_ready}, 32'd1); chk("r_stall0", {31'd0, stall}, 32'd0);
    chk("r_we_none", {31'd0, rf_regwrite}, 32'd0);
    step();
    idle();
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
